// File: rtl/mult_div_unit.sv
// mult_div_unit: sequential signed multiplier / divider serving the control unit.
//   Multiply: radix-2 Booth, one step per cycle, DATA_W steps.
//   Divide:   restoring division on magnitudes, one quotient bit per cycle,
//             sign fix-up on the way out (truncate toward zero).
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   mult_start        request a*b (accepted only when idle and done is low)
//   div_start         request a/b (same acceptance; multiply wins if both high)
//   a, b              operands, sampled on the accepting edge
//   hi, lo            mult: product high/low words; div: remainder/quotient
//   busy              high while an operation is in progress
//   done              one-cycle pulse: hi/lo (or div_zero) valid
//   div_zero          one-cycle pulse with done for a divide by zero
module mult_div_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mult_start,
  input  logic              div_start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              done,
  output logic              div_zero
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] MULT   = 2'd1;
  localparam logic [1:0] DIV    = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  logic [1:0]        state;
  logic [CNT_W-1:0]  count;
  // operand: multiplicand (mult) or divisor magnitude (div)
  logic [DATA_W-1:0] operand;
  // acc/low: Booth {P_hi, P_lo} or {remainder, dividend/quotient}
  logic [DATA_W:0]   acc;
  logic [DATA_W-1:0] low;
  logic              qm1;
  logic              is_div;
  logic              zero_flag;
  logic              neg_q;
  logic              neg_r;

  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic [DATA_W:0]   booth_acc;
  logic [DATA_W:0]   div_shift;
  logic [DATA_W:0]   div_trial;

  assign busy  = (state != IDLE);
  assign a_mag = a[DATA_W-1] ? -a : a;
  assign b_mag = b[DATA_W-1] ? -b : b;

  // Accumulator is one bit wider than the operand so that subtracting the most
  // negative multiplicand cannot overflow before the arithmetic shift.
  always_comb begin
    booth_acc = acc;
    case ({low[0], qm1})
      2'b01:   booth_acc = acc + {operand[DATA_W-1], operand};
      2'b10:   booth_acc = acc - {operand[DATA_W-1], operand};
      default: booth_acc = acc;
    endcase
  end

  // Remainder stays below the divisor (<= 2^(DATA_W-1)), so the shifted value
  // fits in DATA_W+1 bits and the trial's top bit is a valid borrow.
  always_comb begin
    div_shift = {acc[DATA_W-1:0], low[DATA_W-1]};
    div_trial = div_shift - {1'b0, operand};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      operand   <= '0;
      acc       <= '0;
      low       <= '0;
      qm1       <= 1'b0;
      is_div    <= 1'b0;
      zero_flag <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          // done is high during the first idle cycle; starts then are dropped.
          if (mult_start && !done) begin
            operand   <= a;
            low       <= b;
            acc       <= '0;
            qm1       <= 1'b0;
            count     <= '0;
            is_div    <= 1'b0;
            zero_flag <= 1'b0;
            state     <= MULT;
          end else if (div_start && !done) begin
            is_div <= 1'b1;
            if (b == '0) begin
              zero_flag <= 1'b1;
              state     <= FINISH;
            end else begin
              operand   <= b_mag;
              low       <= a_mag;
              acc       <= '0;
              count     <= '0;
              neg_q     <= a[DATA_W-1] ^ b[DATA_W-1];
              neg_r     <= a[DATA_W-1];
              zero_flag <= 1'b0;
              state     <= DIV;
            end
          end
        end
        MULT: begin
          acc   <= {booth_acc[DATA_W], booth_acc[DATA_W:1]};
          low   <= {booth_acc[0], low[DATA_W-1:1]};
          qm1   <= low[0];
          count <= count + 1'b1;
          if (count == LAST) state <= FINISH;
        end
        DIV: begin
          if (!div_trial[DATA_W]) begin
            acc <= div_trial;
            low <= {low[DATA_W-2:0], 1'b1};
          end else begin
            acc <= div_shift;
            low <= {low[DATA_W-2:0], 1'b0};
          end
          count <= count + 1'b1;
          if (count == LAST) state <= FINISH;
        end
        FINISH: begin
          done <= 1'b1;
          if (zero_flag) begin
            div_zero <= 1'b1;
          end else if (is_div) begin
            lo <= neg_q ? -low : low;
            hi <= neg_r ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
          end else begin
            hi <= acc[DATA_W-1:0];
            lo <= low;
          end
          zero_flag <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
